// File: rtl/axi_id_narrow_pkg.sv
// -----------------------------------------------------------------------------
// axi_id_narrow_pkg
// Shared definitions for the AXI ID narrower:
//   - default ID / address / data widths
//   - cnt_width(): width of a per-slot outstanding-transaction counter
//   - num_slots(): number of table slots for a given master-port ID width
//   - default slave-port (wide ID) and master-port (narrow ID) channel structs
// -----------------------------------------------------------------------------
package axi_id_narrow_pkg;

  localparam int unsigned DefaultSlvIdWidth = 6;
  localparam int unsigned DefaultMstIdWidth = 2;
  localparam int unsigned AddrWidth         = 32;
  localparam int unsigned DataWidth         = 32;
  localparam int unsigned StrbWidth         = DataWidth / 8;

  // Counter must represent 0..max_txns inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_txns);
    return (max_txns < 1) ? 1 : $clog2(max_txns + 1);
  endfunction

  function automatic int unsigned num_slots(input int unsigned mst_id_width);
    return 2 ** mst_id_width;
  endfunction

  typedef logic [DefaultSlvIdWidth-1:0] slv_id_t;
  typedef logic [DefaultMstIdWidth-1:0] mst_id_t;
  typedef logic [AddrWidth-1:0]         addr_t;
  typedef logic [DataWidth-1:0]         data_t;

  typedef struct packed {
    slv_id_t    id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } slv_ax_def_t;

  typedef struct packed {
    mst_id_t    id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } mst_ax_def_t;

  typedef struct packed {
    data_t                data;
    logic [StrbWidth-1:0] strb;
    logic                 last;
  } w_def_t;

  typedef struct packed {
    slv_id_t    id;
    logic [1:0] resp;
  } slv_b_def_t;

  typedef struct packed {
    mst_id_t    id;
    logic [1:0] resp;
  } mst_b_def_t;

  typedef struct packed {
    slv_id_t    id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
  } slv_r_def_t;

  typedef struct packed {
    mst_id_t    id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
  } mst_r_def_t;

endpackage

// File: rtl/axi_id_narrow_table.sv
// -----------------------------------------------------------------------------
// axi_id_narrow_table
// One ID map/count table (used once for writes, once for reads).
// Each slot holds the slave ID that owns it plus an outstanding count; a slot
// is free when its count is zero.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   req_id        : slave ID of the pending request (lookup key)
//   req_push      : request handshake this cycle (count up / allocate)
//   req_stall     : request cannot be issued this cycle
//   req_idx       : slot (master ID) the request maps to
//   rsp_idx       : master ID of the response on the bus
//   rsp_valid     : a response beat is presented (protocol check only)
//   rsp_retire    : final response handshake this cycle (count down)
//   rsp_slv_id    : original slave ID restored for the response
// -----------------------------------------------------------------------------
module axi_id_narrow_table
  import axi_id_narrow_pkg::*;
#(
  parameter int unsigned SlvIdWidth = DefaultSlvIdWidth,
  parameter int unsigned MstIdWidth = DefaultMstIdWidth,
  parameter int unsigned MaxTxns    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [SlvIdWidth-1:0] req_id,
  input  logic                  req_push,
  output logic                  req_stall,
  output logic [MstIdWidth-1:0] req_idx,
  input  logic [MstIdWidth-1:0] rsp_idx,
  input  logic                  rsp_valid,
  input  logic                  rsp_retire,
  output logic [SlvIdWidth-1:0] rsp_slv_id
);

  localparam int unsigned NumSlots = num_slots(MstIdWidth);
  localparam int unsigned CntWidth = cnt_width(MaxTxns);

  typedef logic [CntWidth-1:0] cnt_t;
  localparam cnt_t CntMax = cnt_t'(MaxTxns);

  typedef struct packed {
    logic [SlvIdWidth-1:0] slv_id;
    cnt_t                  cnt;
  } slot_t;

  slot_t slots [NumSlots];

  logic                  hit;
  logic                  free_found;
  logic [MstIdWidth-1:0] hit_idx;
  logic [MstIdWidth-1:0] free_idx;
  logic [NumSlots-1:0]   inc;
  logic [NumSlots-1:0]   dec;

  // Lookup: an ID is held by at most one busy slot; free slots are searched
  // lowest index first. Both use registered counts, so a slot freed this cycle
  // is only visible as free next cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < NumSlots; i++) begin
      if (!hit && slots[i].cnt != '0 && slots[i].slv_id == req_id) begin
        hit     = 1'b1;
        hit_idx = MstIdWidth'(i);
      end
      if (!free_found && slots[i].cnt == '0) begin
        free_found = 1'b1;
        free_idx   = MstIdWidth'(i);
      end
    end
  end

  assign req_idx    = hit ? hit_idx : free_idx;
  assign req_stall  = hit ? (slots[hit_idx].cnt == CntMax) : !free_found;
  assign rsp_slv_id = slots[rsp_idx].slv_id;

  always_comb begin
    inc          = '0;
    dec          = '0;
    inc[req_idx] = req_push;
    dec[rsp_idx] = rsp_retire;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      // NOTE: the table is only a few flops and clearing it is what frees
      // every slot, so it is reset explicitly rather than left undefined.
      for (int i = 0; i < NumSlots; i++) begin
        slots[i] <= '0;
      end
    end else begin
      // NOTE: state updates are non-blocking so every slot sees the pre-edge
      // table, independent of statement order.
      for (int i = 0; i < NumSlots; i++) begin
        if (inc[i] && !dec[i]) begin
          slots[i].cnt <= slots[i].cnt + cnt_t'(1);
        end else if (dec[i] && !inc[i]) begin
          slots[i].cnt <= slots[i].cnt - cnt_t'(1);
        end
      end
      if (req_push && !hit) begin
        slots[req_idx].slv_id <= req_id;
      end
    end
  end

  // A response can only belong to a slot with outstanding transactions.
  rsp_to_free_slot : assert property (
    @(posedge clk_i) disable iff (!rst_ni) rsp_valid |-> slots[rsp_idx].cnt != '0
  ) else $error("axi_id_narrow_table: response on free slot %0d", rsp_idx);

endmodule

// File: rtl/axi_id_narrow.sv
// -----------------------------------------------------------------------------
// axi_id_narrow
// Narrows AXI IDs from a wide slave port to a narrow master port. Each
// in-flight slave ID is mapped to a master-ID slot; B and R responses get the
// original slave ID back. A slave ID never occupies two slots, so same-ID
// ordering is preserved.
//   clk_i, rst_ni      : clock, synchronous active-low reset
//   slv_aw/w/ar_*      : slave-port requests (wide IDs)
//   slv_b/r_*          : slave-port responses (wide IDs restored)
//   mst_aw/w/ar_*      : master-port requests (narrow IDs = slot index)
//   mst_b/r_*          : master-port responses (narrow IDs)
// -----------------------------------------------------------------------------
module axi_id_narrow
  import axi_id_narrow_pkg::*;
#(
  parameter int unsigned AxiIdWidthSlvPort = DefaultSlvIdWidth,
  parameter int unsigned AxiIdWidthMstPort = DefaultMstIdWidth,
  parameter int unsigned MaxTxnsPerId      = 4,
  parameter type slv_aw_chan_t = slv_ax_def_t,
  parameter type slv_w_chan_t  = w_def_t,
  parameter type slv_b_chan_t  = slv_b_def_t,
  parameter type slv_ar_chan_t = slv_ax_def_t,
  parameter type slv_r_chan_t  = slv_r_def_t,
  parameter type mst_aw_chan_t = mst_ax_def_t,
  parameter type mst_w_chan_t  = w_def_t,
  parameter type mst_b_chan_t  = mst_b_def_t,
  parameter type mst_ar_chan_t = mst_ax_def_t,
  parameter type mst_r_chan_t  = mst_r_def_t
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  slv_aw_chan_t slv_aw_chan_i,
  input  logic         slv_aw_valid_i,
  output logic         slv_aw_ready_o,
  input  slv_w_chan_t  slv_w_chan_i,
  input  logic         slv_w_valid_i,
  output logic         slv_w_ready_o,
  output slv_b_chan_t  slv_b_chan_o,
  output logic         slv_b_valid_o,
  input  logic         slv_b_ready_i,
  input  slv_ar_chan_t slv_ar_chan_i,
  input  logic         slv_ar_valid_i,
  output logic         slv_ar_ready_o,
  output slv_r_chan_t  slv_r_chan_o,
  output logic         slv_r_valid_o,
  input  logic         slv_r_ready_i,
  output mst_aw_chan_t mst_aw_chan_o,
  output logic         mst_aw_valid_o,
  input  logic         mst_aw_ready_i,
  output mst_w_chan_t  mst_w_chan_o,
  output logic         mst_w_valid_o,
  input  logic         mst_w_ready_i,
  input  mst_b_chan_t  mst_b_chan_i,
  input  logic         mst_b_valid_i,
  output logic         mst_b_ready_o,
  output mst_ar_chan_t mst_ar_chan_o,
  output logic         mst_ar_valid_o,
  input  logic         mst_ar_ready_i,
  input  mst_r_chan_t  mst_r_chan_i,
  input  logic         mst_r_valid_i,
  output logic         mst_r_ready_o
);

  if (AxiIdWidthMstPort >= AxiIdWidthSlvPort) begin : g_bad_id_width
    $error("axi_id_narrow: AxiIdWidthMstPort must be smaller than AxiIdWidthSlvPort");
  end
  if (MaxTxnsPerId < 1) begin : g_bad_max_txns
    $error("axi_id_narrow: MaxTxnsPerId must be at least 1");
  end

  logic                         wr_stall;
  logic                         rd_stall;
  logic [AxiIdWidthMstPort-1:0] wr_idx;
  logic [AxiIdWidthMstPort-1:0] rd_idx;
  logic [AxiIdWidthSlvPort-1:0] wr_rsp_slv_id;
  logic [AxiIdWidthSlvPort-1:0] rd_rsp_slv_id;

  axi_id_narrow_table #(
    .SlvIdWidth (AxiIdWidthSlvPort),
    .MstIdWidth (AxiIdWidthMstPort),
    .MaxTxns    (MaxTxnsPerId)
  ) u_wr_table (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_id     (slv_aw_chan_i.id),
    .req_push   (mst_aw_valid_o && mst_aw_ready_i),
    .req_stall  (wr_stall),
    .req_idx    (wr_idx),
    .rsp_idx    (mst_b_chan_i.id),
    .rsp_valid  (mst_b_valid_i),
    .rsp_retire (mst_b_valid_i && slv_b_ready_i),
    .rsp_slv_id (wr_rsp_slv_id)
  );

  axi_id_narrow_table #(
    .SlvIdWidth (AxiIdWidthSlvPort),
    .MstIdWidth (AxiIdWidthMstPort),
    .MaxTxns    (MaxTxnsPerId)
  ) u_rd_table (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_id     (slv_ar_chan_i.id),
    .req_push   (mst_ar_valid_o && mst_ar_ready_i),
    .req_stall  (rd_stall),
    .req_idx    (rd_idx),
    .rsp_idx    (mst_r_chan_i.id),
    .rsp_valid  (mst_r_valid_i),
    .rsp_retire (mst_r_valid_i && slv_r_ready_i && mst_r_chan_i.last),
    .rsp_slv_id (rd_rsp_slv_id)
  );

  // Requests: the stall gates both directions of the handshake; master valid
  // depends only on slave valid and the table, never on master ready.
  assign mst_aw_valid_o = slv_aw_valid_i && !wr_stall;
  assign slv_aw_ready_o = mst_aw_ready_i && !wr_stall;
  assign mst_ar_valid_o = slv_ar_valid_i && !rd_stall;
  assign slv_ar_ready_o = mst_ar_ready_i && !rd_stall;

  always_comb begin
    mst_aw_chan_o       = '0;
    mst_aw_chan_o.id    = wr_idx;
    mst_aw_chan_o.addr  = slv_aw_chan_i.addr;
    mst_aw_chan_o.len   = slv_aw_chan_i.len;
    mst_aw_chan_o.size  = slv_aw_chan_i.size;
    mst_aw_chan_o.burst = slv_aw_chan_i.burst;

    mst_ar_chan_o       = '0;
    mst_ar_chan_o.id    = rd_idx;
    mst_ar_chan_o.addr  = slv_ar_chan_i.addr;
    mst_ar_chan_o.len   = slv_ar_chan_i.len;
    mst_ar_chan_o.size  = slv_ar_chan_i.size;
    mst_ar_chan_o.burst = slv_ar_chan_i.burst;
  end

  // W carries no ID and passes straight through.
  assign mst_w_chan_o  = slv_w_chan_i;
  assign mst_w_valid_o = slv_w_valid_i;
  assign slv_w_ready_o = mst_w_ready_i;

  // Responses: restore the slave ID from the slot, pass everything else.
  assign slv_b_valid_o = mst_b_valid_i;
  assign mst_b_ready_o = slv_b_ready_i;
  assign slv_r_valid_o = mst_r_valid_i;
  assign mst_r_ready_o = slv_r_ready_i;

  always_comb begin
    slv_b_chan_o      = '0;
    slv_b_chan_o.id   = wr_rsp_slv_id;
    slv_b_chan_o.resp = mst_b_chan_i.resp;

    slv_r_chan_o      = '0;
    slv_r_chan_o.id   = rd_rsp_slv_id;
    slv_r_chan_o.data = mst_r_chan_i.data;
    slv_r_chan_o.resp = mst_r_chan_i.resp;
    slv_r_chan_o.last = mst_r_chan_i.last;
  end

endmodule

// File: tb/tb_axi_id_narrow.sv
// -----------------------------------------------------------------------------
// tb_axi_id_narrow
// Directed and randomized stimulus for axi_id_narrow (6-bit slave IDs, 2-bit
// master IDs, two outstanding transactions per slot). The reference model
// keeps, per direction and per master-ID slot, a queue of the slave IDs still
// outstanding there; a slot is free when its queue is empty and its owner is
// the ID at the queue front.
// -----------------------------------------------------------------------------
module tb_axi_id_narrow;
  import axi_id_narrow_pkg::*;

  localparam int MaxT   = 2;
  localparam int NSlots = 4;

  logic clk    = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  slv_ax_def_t slv_aw_chan_i, slv_ar_chan_i;
  mst_ax_def_t mst_aw_chan_o, mst_ar_chan_o;
  w_def_t      slv_w_chan_i, mst_w_chan_o;
  slv_b_def_t  slv_b_chan_o;
  mst_b_def_t  mst_b_chan_i;
  slv_r_def_t  slv_r_chan_o;
  mst_r_def_t  mst_r_chan_i;
  logic slv_aw_valid_i, slv_aw_ready_o, slv_w_valid_i, slv_w_ready_o;
  logic slv_b_valid_o, slv_b_ready_i, slv_ar_valid_i, slv_ar_ready_o;
  logic slv_r_valid_o, slv_r_ready_i;
  logic mst_aw_valid_o, mst_aw_ready_i, mst_w_valid_o, mst_w_ready_i;
  logic mst_b_valid_i, mst_b_ready_o, mst_ar_valid_o, mst_ar_ready_i;
  logic mst_r_valid_i, mst_r_ready_o;

  axi_id_narrow #(
    .AxiIdWidthSlvPort (6),
    .AxiIdWidthMstPort (2),
    .MaxTxnsPerId      (MaxT)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .slv_aw_chan_i  (slv_aw_chan_i),
    .slv_aw_valid_i (slv_aw_valid_i),
    .slv_aw_ready_o (slv_aw_ready_o),
    .slv_w_chan_i   (slv_w_chan_i),
    .slv_w_valid_i  (slv_w_valid_i),
    .slv_w_ready_o  (slv_w_ready_o),
    .slv_b_chan_o   (slv_b_chan_o),
    .slv_b_valid_o  (slv_b_valid_o),
    .slv_b_ready_i  (slv_b_ready_i),
    .slv_ar_chan_i  (slv_ar_chan_i),
    .slv_ar_valid_i (slv_ar_valid_i),
    .slv_ar_ready_o (slv_ar_ready_o),
    .slv_r_chan_o   (slv_r_chan_o),
    .slv_r_valid_o  (slv_r_valid_o),
    .slv_r_ready_i  (slv_r_ready_i),
    .mst_aw_chan_o  (mst_aw_chan_o),
    .mst_aw_valid_o (mst_aw_valid_o),
    .mst_aw_ready_i (mst_aw_ready_i),
    .mst_w_chan_o   (mst_w_chan_o),
    .mst_w_valid_o  (mst_w_valid_o),
    .mst_w_ready_i  (mst_w_ready_i),
    .mst_b_chan_i   (mst_b_chan_i),
    .mst_b_valid_i  (mst_b_valid_i),
    .mst_b_ready_o  (mst_b_ready_o),
    .mst_ar_chan_o  (mst_ar_chan_o),
    .mst_ar_valid_o (mst_ar_valid_o),
    .mst_ar_ready_i (mst_ar_ready_i),
    .mst_r_chan_i   (mst_r_chan_i),
    .mst_r_valid_i  (mst_r_valid_i),
    .mst_r_ready_o  (mst_r_ready_o)
  );

  int compared   = 0;
  int mismatched = 0;

  // [0] = write table, [1] = read table; each queue lists outstanding slave IDs.
  int tq [2][NSlots][$];

  typedef struct {
    bit         aw_v;
    logic [5:0] aw_id;
    bit         aw_rdy;
    bit         b_v;
    logic [1:0] b_id;
    bit         ar_v;
    logic [5:0] ar_id;
    bit         ar_rdy;
    bit         r_v;
    logic [1:0] r_id;
    bit         r_last;
  } stim_t;

  function automatic stim_t nop();
    stim_t s;
    s.aw_v = 1'b0; s.aw_id = '0; s.aw_rdy = 1'b1;
    s.b_v  = 1'b0; s.b_id  = '0;
    s.ar_v = 1'b0; s.ar_id = '0; s.ar_rdy = 1'b1;
    s.r_v  = 1'b0; s.r_id  = '0; s.r_last = 1'b0;
    return s;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slot choice from the mapping rules: an ID already outstanding reuses its
  // slot unless that slot is full; a new ID takes the lowest empty slot.
  task automatic model_lookup(input int d, input int id, output bit stall, output int slot);
    stall = 1'b1;
    slot  = 0;
    for (int s = 0; s < NSlots; s++) begin
      if (tq[d][s].size() > 0 && tq[d][s][0] == id) begin
        slot  = s;
        stall = (tq[d][s].size() >= MaxT);
        return;
      end
    end
    for (int s = 0; s < NSlots; s++) begin
      if (tq[d][s].size() == 0) begin
        slot  = s;
        stall = 1'b0;
        return;
      end
    end
  endtask

  function automatic int pick_busy(input int d);
    int c[$];
    for (int s = 0; s < NSlots; s++) if (tq[d][s].size() > 0) c.push_back(s);
    if (c.size() == 0) return -1;
    return c[$urandom_range(0, c.size() - 1)];
  endfunction

  task automatic idle_inputs();
    slv_aw_chan_i  = '0; slv_aw_valid_i = 1'b0; mst_aw_ready_i = 1'b0;
    slv_w_chan_i   = '0; slv_w_valid_i  = 1'b0; mst_w_ready_i  = 1'b0;
    mst_b_chan_i   = '0; mst_b_valid_i  = 1'b0; slv_b_ready_i  = 1'b1;
    slv_ar_chan_i  = '0; slv_ar_valid_i = 1'b0; mst_ar_ready_i = 1'b0;
    mst_r_chan_i   = '0; mst_r_valid_i  = 1'b0; slv_r_ready_i  = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_mst_aw_valid"}, mst_aw_valid_o, 1'b0);
    check({tag, "_mst_ar_valid"}, mst_ar_valid_o, 1'b0);
    check({tag, "_mst_w_valid"},  mst_w_valid_o,  1'b0);
    check({tag, "_slv_b_valid"},  slv_b_valid_o,  1'b0);
    check({tag, "_slv_r_valid"},  slv_r_valid_o,  1'b0);
  endtask

  // One clock cycle: drive at the falling edge, check 1 ns later, then let the
  // rising edge commit and advance the model by the handshakes it predicts.
  task automatic run(input stim_t s);
    bit          aw_st, ar_st;
    int          aw_sl, ar_sl;
    logic [31:0] aw_addr, ar_addr, w_data, r_data;
    logic [1:0]  b_resp, r_resp;
    logic        w_v, w_rdy;
    @(negedge clk);
    aw_addr = $urandom; ar_addr = $urandom; w_data = $urandom; r_data = $urandom;
    b_resp  = 2'($urandom_range(0, 3)); r_resp = 2'($urandom_range(0, 3));
    w_v     = 1'($urandom_range(0, 1)); w_rdy  = 1'($urandom_range(0, 1));

    slv_aw_chan_i       = '0;
    slv_aw_chan_i.id    = s.aw_id;
    slv_aw_chan_i.addr  = aw_addr;
    slv_aw_chan_i.len   = 8'h3;
    slv_aw_valid_i      = s.aw_v;
    mst_aw_ready_i      = s.aw_rdy;
    mst_b_chan_i.id     = s.b_id;
    mst_b_chan_i.resp   = b_resp;
    mst_b_valid_i       = s.b_v;
    slv_ar_chan_i       = '0;
    slv_ar_chan_i.id    = s.ar_id;
    slv_ar_chan_i.addr  = ar_addr;
    slv_ar_chan_i.len   = 8'h3;
    slv_ar_valid_i      = s.ar_v;
    mst_ar_ready_i      = s.ar_rdy;
    mst_r_chan_i.id     = s.r_id;
    mst_r_chan_i.data   = r_data;
    mst_r_chan_i.resp   = r_resp;
    mst_r_chan_i.last   = s.r_last;
    mst_r_valid_i       = s.r_v;
    slv_w_chan_i.data   = w_data;
    slv_w_chan_i.strb   = 4'hF;
    slv_w_chan_i.last   = 1'b1;
    slv_w_valid_i       = w_v;
    mst_w_ready_i       = w_rdy;
    #1;

    model_lookup(0, int'(s.aw_id), aw_st, aw_sl);
    model_lookup(1, int'(s.ar_id), ar_st, ar_sl);

    check("aw_valid", mst_aw_valid_o, s.aw_v && !aw_st);
    if (s.aw_v) check("aw_ready", slv_aw_ready_o, s.aw_rdy && !aw_st);
    if (s.aw_v && !aw_st) begin
      check("aw_mst_id", mst_aw_chan_o.id, aw_sl);
      check("aw_addr", mst_aw_chan_o.addr, aw_addr);
    end
    check("ar_valid", mst_ar_valid_o, s.ar_v && !ar_st);
    if (s.ar_v) check("ar_ready", slv_ar_ready_o, s.ar_rdy && !ar_st);
    if (s.ar_v && !ar_st) begin
      check("ar_mst_id", mst_ar_chan_o.id, ar_sl);
      check("ar_addr", mst_ar_chan_o.addr, ar_addr);
    end
    check("b_valid", slv_b_valid_o, s.b_v);
    if (s.b_v) begin
      check("b_slv_id", slv_b_chan_o.id, tq[0][s.b_id][0]);
      check("b_resp", slv_b_chan_o.resp, b_resp);
    end
    check("r_valid", slv_r_valid_o, s.r_v);
    if (s.r_v) begin
      check("r_slv_id", slv_r_chan_o.id, tq[1][s.r_id][0]);
      check("r_data", slv_r_chan_o.data, r_data);
      check("r_last", slv_r_chan_o.last, s.r_last);
    end
    check("w_valid", mst_w_valid_o, w_v);
    check("w_ready", slv_w_ready_o, w_rdy);
    check("w_data", mst_w_chan_o.data, w_data);

    @(posedge clk);
    if (s.aw_v && !aw_st && s.aw_rdy) tq[0][aw_sl].push_back(int'(s.aw_id));
    if (s.b_v) void'(tq[0][s.b_id].pop_front());
    if (s.ar_v && !ar_st && s.ar_rdy) tq[1][ar_sl].push_back(int'(s.ar_id));
    if (s.r_v && s.r_last) void'(tq[1][s.r_id].pop_front());
  endtask

  task automatic aw(input logic [5:0] id);
    stim_t s;
    s = nop(); s.aw_v = 1'b1; s.aw_id = id;
    run(s);
  endtask

  task automatic b(input logic [1:0] idx);
    stim_t s;
    s = nop(); s.b_v = 1'b1; s.b_id = idx;
    run(s);
  endtask

  task automatic aw_b(input logic [5:0] id, input logic [1:0] idx);
    stim_t s;
    s = nop(); s.aw_v = 1'b1; s.aw_id = id; s.b_v = 1'b1; s.b_id = idx;
    run(s);
  endtask

  task automatic ar_r(input bit ar_v, input logic [5:0] id, input bit r_v,
                      input logic [1:0] idx, input bit last);
    stim_t s;
    s = nop(); s.ar_v = ar_v; s.ar_id = id; s.r_v = r_v; s.r_id = idx; s.r_last = last;
    run(s);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < NSlots; s++) tq[d][s].delete();
    #1;
  endtask

  localparam logic [5:0] IdPool [6] = '{6'h00, 6'h01, 6'h15, 6'h2A, 6'h3F, 6'h20};

  initial begin
    stim_t s;
    int    p;
    idle_inputs();
    apply_reset();
    check_idle_outputs("reset");

    // Single write, response, slot reuse by a new ID.
    aw(6'h2A);
    b(2'd0);
    aw(6'h11);
    b(2'd0);

    // Same ID three times: third stalls until one retires.
    aw(6'h2A);
    aw(6'h2A);
    aw(6'h2A);
    aw_b(6'h2A, 2'd0);
    aw(6'h2A);
    b(2'd0);
    b(2'd0);

    // Fill every slot, overflow stalls, freed slot reusable next cycle only.
    aw(6'h01); aw(6'h02); aw(6'h03); aw(6'h04);
    aw(6'h05);
    aw_b(6'h05, 2'd1);
    aw(6'h05);
    b(2'd1);
    b(2'd0); b(2'd2); b(2'd3);

    // Read burst: non-last beats keep the slot busy, last beat frees it.
    ar_r(1'b1, 6'h3F, 1'b0, 2'd0, 1'b0);
    ar_r(1'b0, 6'h00, 1'b1, 2'd0, 1'b0);
    ar_r(1'b1, 6'h20, 1'b1, 2'd0, 1'b0);
    ar_r(1'b0, 6'h00, 1'b1, 2'd0, 1'b0);
    ar_r(1'b0, 6'h00, 1'b1, 2'd0, 1'b1);
    ar_r(1'b1, 6'h21, 1'b0, 2'd0, 1'b0);
    ar_r(1'b0, 6'h00, 1'b1, 2'd1, 1'b1);
    ar_r(1'b0, 6'h00, 1'b1, 2'd0, 1'b1);

    // Simultaneous push and retire on the same slot.
    aw(6'h01); aw(6'h02); aw(6'h10);
    aw_b(6'h10, 2'd2);
    b(2'd2);
    b(2'd0); b(2'd1);

    // Reset with all slots full, then a fresh ID lands in slot 0.
    aw(6'h08); aw(6'h09); aw(6'h0A); aw(6'h0B);
    ar_r(1'b1, 6'h0C, 1'b0, 2'd0, 1'b0);
    apply_reset();
    check_idle_outputs("post_reset");
    aw(6'h07);
    b(2'd0);

    // Randomized traffic on both directions.
    for (int n = 0; n < 400; n++) begin
      s = nop();
      s.aw_v   = 1'($urandom_range(0, 1));
      s.aw_id  = IdPool[$urandom_range(0, 5)];
      s.aw_rdy = 1'($urandom_range(0, 3) != 0);
      p = pick_busy(0);
      if (p >= 0 && $urandom_range(0, 2) != 0) begin
        s.b_v = 1'b1; s.b_id = 2'(p);
      end
      s.ar_v   = 1'($urandom_range(0, 1));
      s.ar_id  = IdPool[$urandom_range(0, 5)];
      s.ar_rdy = 1'($urandom_range(0, 3) != 0);
      p = pick_busy(1);
      if (p >= 0 && $urandom_range(0, 2) != 0) begin
        s.r_v = 1'b1; s.r_id = 2'(p); s.r_last = 1'($urandom_range(0, 1));
      end
      run(s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
